frame_deserializer: RTL and testbench
=====================================

Name: frame_deserializer

Overview:
- Serial-to-parallel receiver that samples a 1-bit serial line once per clock. One bit per clock, no oversampling.
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, stop bit (1).
- Delivers each received word on a parallel output with an end-of-block strobe and an error strobe.
- Sits at the receive edge of the serial link in the 25 MHz domain.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (range 2..32).
- PARITY_EN, 1, 1 = parity bit present between last data bit and stop bit; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity (data bits plus parity bit have an even count of ones); 1 = odd parity.

Ports:
- clk_i  input  1  system clock; all sampling on the rising edge.
- rst_i  input  1  asynchronous active-low reset.
- inputdata_i  input  1  serial line; idle level 1.
- outputdata_o  output  DATA_WIDTH  last correctly received word (registered).
- err_o  output  1  one-cycle pulse: the frame just ended had a parity or stop-bit error.
- eob_o  output  1  one-cycle pulse: end of block, i.e. a frame just completed (good or bad).

Behaviour:
- Reset (rst_i=0, asynchronous) forces the following, and any partial frame is discarded:
  - outputdata_o=0, err_o=0, eob_o=0.
  - Shift register, bit counter and parity accumulator cleared.
  - FSM to IDLE.
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: inputdata_i=0 sampled -> start bit accepted -> DATA, counter=0. Input 1 -> stay.
- DATA: shift the sampled bit into position counter (LSB first) and XOR it into the parity accumulator.
  - After DATA_WIDTH bits -> PARITY if PARITY_EN, else STOP.
- PARITY: sampled bit XORed into the accumulator.
  - Parity error = accumulator != PARITY_ODD.
  - -> STOP.
- STOP: sample the stop bit.
  - Good frame (stop=1 and no parity error): outputdata_o <= assembled word; eob_o=1; err_o=0 next cycle; -> IDLE.
  - Parity error with stop=1: eob_o=1 and err_o=1; outputdata_o unchanged; -> IDLE.
  - Stop=0 (framing error, parity result irrelevant): eob_o=1 and err_o=1; outputdata_o unchanged; -> WAIT_IDLE.
- WAIT_IDLE: ignore the line until inputdata_i=1 is sampled -> IDLE. This prevents a stuck-low line from being read as back-to-back start bits.
- Latency: start bit sampled at edge k.
  - Data bits sampled at edges k+1..k+DATA_WIDTH.
  - Parity at k+DATA_WIDTH+1 (when enabled).
  - Stop at the next edge, s = k+DATA_WIDTH+1+PARITY_EN.
  - eob_o/err_o/outputdata_o are updated at edge s and visible for exactly one cycle (outputdata_o holds).
- Back-to-back frames: the start bit of the next frame may be sampled at edge s+1 with no idle gap. No bit is lost.
- eob_o and err_o are never high for more than one consecutive cycle per frame. err_o=1 only ever coincides with eob_o=1.
- No start-bit glitch filtering: a single 0 sample in IDLE starts a frame.
- Mid-frame reset: outputs go to their reset values immediately; reception restarts in IDLE after release.

Test Plan:
- Idle line held 1 for 50 cycles after reset release -> eob_o, err_o stay 0; outputdata_o=0x00.
- Defaults, word 0xA5, even parity: serial sequence 0,1,0,1,0,0,1,0,1,0,1 -> exactly one cycle with eob_o=1, err_o=0; outputdata_o=0xA5 from the stop-bit edge onward.
- Parity error: word 0x3C sent with parity bit 1 (correct is 0), stop 1 -> eob_o=1 and err_o=1 in the same single cycle; outputdata_o keeps the previous value (0xA5).
- Framing error: 0x55 with correct parity, stop bit 0, line then held 0 for 5 cycles, then 1 -> eob_o=err_o=1 pulse; no further frames start while low. A subsequent good frame 0x0F is received correctly.
- Back-to-back: frames 0x01 (parity 1) and 0xFF (parity 0) with no idle gap -> two eob_o pulses 11 cycles apart; outputdata_o=0x01 then 0xFF; err_o never 1.
- Reset mid-frame: assert rst_i low after 4 data bits of 0x81, release, then send 0x7E -> outputs 0 during reset; only one eob_o, with outputdata_o=0x7E and err_o=0.

Source files
------------

// File: rtl/frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : frame_deserializer
// Description : One-sample-per-clock serial receiver. Frame is start (0),
//               DATA_WIDTH data bits LSB first, optional parity, stop (1).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_deserializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inputdata_i,
    output logic [DATA_WIDTH-1:0] outputdata_o,
    output logic                  err_o,
    output logic                  eob_o
);

    localparam int unsigned      CNT_W  = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DATA      = 3'd1,
        S_PARITY    = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_par;
    logic                  w_par_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  r_eob;
    logic                  w_eob_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_par_err;

    // Accumulator already includes the received parity bit when in STOP.
    assign w_par_err = PARITY_EN && (r_par != PARITY_ODD);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_data  <= '0;
            r_eob   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_par   <= w_par_nxt;
            r_data  <= w_data_nxt;
            r_eob   <= w_eob_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;
        w_data_nxt  = r_data;
        w_eob_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!inputdata_i) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_par_nxt   = 1'b0;
                end
            end
            S_DATA: begin
                // Right shift: after DATA_WIDTH samples the first bit sits at bit 0.
                w_shift_nxt = {inputdata_i, r_shift[DATA_WIDTH-1:1]};
                w_par_nxt   = r_par ^ inputdata_i;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (r_cnt == c_last) begin
                    w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_par_nxt   = r_par ^ inputdata_i;
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_eob_nxt = 1'b1;
                if (!inputdata_i) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_WAIT_IDLE;
                end else if (w_par_err) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_data_nxt  = r_shift;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (inputdata_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign outputdata_o = r_data;
    assign eob_o        = r_eob;
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_deserializer
// Description : Scoreboard bench for frame_deserializer (8 data bits, even parity).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_deserializer;

    logic       clk;
    logic       rst_n;
    logic       line;
    logic [7:0] dout;
    logic       err;
    logic       eob;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } obs_t;

    logic [8:0] exp_q[$];
    obs_t       obs_q[$];
    int         cyc      = 0;
    int         bad_err  = 0;
    int         long_eob = 0;
    logic       prev_eob = 1'b0;

    frame_deserializer #(
        .DATA_WIDTH (8),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .inputdata_i  (line),
        .outputdata_o (dout),
        .err_o        (err),
        .eob_o        (eob)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Records every end-of-block pulse and any pulse-shape violation.
    always @(posedge clk) begin
        obs_t o;
        #1;
        cyc = cyc + 1;
        if (eob) begin
            o.err  = err;
            o.data = dout;
            o.cyc  = cyc;
            obs_q.push_back(o);
        end
        if (err && !eob) bad_err = bad_err + 1;
        if (eob && prev_eob) long_eob = long_eob + 1;
        prev_eob = eob;
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        line = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // Drives one frame; parity_flip corrupts the even-parity bit.
    task automatic send_frame(input logic [7:0] d, input logic parity_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((^d) ^ parity_flip);
        send_bit(stop);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        line  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", dout); end
        tests++; if (eob !== 1'b0) begin fails++; $display("FAIL reset_eob: got %b expected 0", eob); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(50);
        #1;
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL idle_eob: got %0d pulses expected 0", obs_q.size()); end
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL idle_data: got %h expected 00", dout); end
        obs_q.delete();
    endtask

    task automatic test_good;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL good_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            logic [8:0] e = exp_q.pop_front();
            obs_t       o = obs_q.pop_front();
            tests++; if ({o.err, o.data} !== e) begin fails++; $display("FAIL good_word: got err=%b data=%h expected err=%b data=%h", o.err, o.data, e[8], e[7:0]); end
        end
        tests++; if (dout !== 8'hA5) begin fails++; $display("FAIL good_hold: got %h expected a5", dout); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_parity_error;
        exp_q.push_back({1'b1, 8'hA5});
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(4);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL parity_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            logic [8:0] e = exp_q.pop_front();
            obs_t       o = obs_q.pop_front();
            tests++; if ({o.err, o.data} !== e) begin fails++; $display("FAIL parity_word: got err=%b data=%h expected err=%b data=%h", o.err, o.data, e[8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_framing_error;
        exp_q.push_back({1'b1, 8'hA5});
        send_frame(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        idle(3);
        exp_q.push_back({1'b0, 8'h0F});
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(4);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL framing_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            logic [8:0] e = exp_q.pop_front();
            obs_t       o = obs_q.pop_front();
            tests++; if ({o.err, o.data} !== e) begin fails++; $display("FAIL framing_word: got err=%b data=%h expected err=%b data=%h", o.err, o.data, e[8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        int first_cyc = -1;
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(4);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            logic [8:0] e = exp_q.pop_front();
            obs_t       o = obs_q.pop_front();
            tests++; if ({o.err, o.data} !== e) begin fails++; $display("FAIL b2b_word: got err=%b data=%h expected err=%b data=%h", o.err, o.data, e[8], e[7:0]); end
            if (first_cyc < 0) begin
                first_cyc = o.cyc;
            end else begin
                tests++; if (o.cyc - first_cyc != 11) begin fails++; $display("FAIL b2b_spacing: got %0d cycles expected 11", o.cyc - first_cyc); end
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        @(negedge clk);
        rst_n = 1'b0;
        line  = 1'b1;
        #1;
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h expected 00", dout); end
        repeat (2) @(negedge clk);
        tests++; if (eob !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL midrst_flags: got eob=%b err=%b expected 0 0", eob, err); end
        rst_n = 1'b1;
        idle(2);
        exp_q.push_back({1'b0, 8'h7E});
        send_frame(8'h7E, 1'b0, 1'b1);
        idle(12);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL midrst_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            logic [8:0] e = exp_q.pop_front();
            obs_t       o = obs_q.pop_front();
            tests++; if ({o.err, o.data} !== e) begin fails++; $display("FAIL midrst_word: got err=%b data=%h expected err=%b data=%h", o.err, o.data, e[8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_pulse_shape;
        tests++; if (bad_err != 0) begin fails++; $display("FAIL err_without_eob: got %0d cycles expected 0", bad_err); end
        tests++; if (long_eob != 0) begin fails++; $display("FAIL eob_width: got %0d stretched cycles expected 0", long_eob); end
    endtask

    initial begin
        test_reset();
        test_good();
        test_parity_error();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_pulse_shape();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
